// File: rtl/xor_stream_cipher_mc.sv
// Multi-channel serial XOR stream cipher.
// A serially loaded key seeds one keystream register per channel; each channel
// advances its keystream (rotate or Galois LFSR) only when it accepts a data bit.
module xor_stream_cipher_mc #(
    parameter int unsigned    M    = 32,
    parameter int unsigned    CH   = 2,
    parameter logic [M-1:0]   TAPS = 32'h8020_0003,
    parameter int unsigned    HB_W = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_en,
    input  logic          cfg_i,
    output logic          cfg_o,
    input  logic          mode,
    input  logic          resync,
    input  logic [CH-1:0] din,
    input  logic [CH-1:0] din_vld,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] dout_vld,
    output logic          keyed,
    output logic [2:0]    heartbeat
);

    typedef enum logic [1:0] {
        StUnkeyed,
        StCfg,
        StRun
    } state_e;

    localparam logic [M-1:0]    OneM  = {{(M-1){1'b0}}, 1'b1};
    localparam logic [HB_W-1:0] OneHb = {{(HB_W-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [M-1:0]    key_q;
    logic            mode_q;
    logic [M-1:0]    s_q [CH];
    logic [M-1:0]    s_d [CH];
    logic [CH-1:0]   dout_q, dout_d;
    logic [CH-1:0]   dout_vld_q, dout_vld_d;
    logic [HB_W-1:0] hb_q;

    logic            commit;
    logic            accept;
    logic            reload;
    logic            reload_mode;
    logic [M-1:0]    reload_val;

    // One keystream step: rotate right, or Galois right-shift with tap feedback.
    function automatic logic [M-1:0] step(input logic [M-1:0] s, input logic lfsr);
        if (lfsr) begin
            return (s >> 1) ^ (s[0] ? TAPS : '0);
        end
        return {s[0], s[M-1:1]};
    endfunction

    // Next-state decode for the keying FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StUnkeyed: if (cfg_en)  state_d = StCfg;
            StCfg:     if (!cfg_en) state_d = StRun;
            StRun:     if (cfg_en)  state_d = StCfg;
            default:   state_d = StUnkeyed;
        endcase
    end

    // Reload/advance decisions; data is only accepted while staying in RUN.
    always_comb begin
        commit      = (state_q == StCfg) && !cfg_en;
        accept      = (state_q == StRun) && !cfg_en;
        reload      = commit || (accept && resync);
        // The fresh mode applies to the commit reload; resync reuses the latched one.
        reload_mode = commit ? mode : mode_q;
        // An all-zero LFSR would never leave zero, so seed it with 1 instead.
        reload_val  = (reload_mode && (key_q == '0)) ? OneM : key_q;
    end

    // Per-channel keystream update and registered XOR output.
    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = '0;
        for (int c = 0; c < int'(CH); c++) begin
            s_d[c] = s_q[c];
            if (accept && din_vld[c]) begin
                dout_d[c]     = din[c] ^ s_q[c][0];
                dout_vld_d[c] = 1'b1;
                s_d[c]        = step(s_q[c], mode_q);
            end
            // Reload wins over a coincident advance.
            if (reload) begin
                s_d[c] = reload_val;
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StUnkeyed;
            key_q      <= '0;
            mode_q     <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= '0;
            hb_q       <= '0;
            for (int c = 0; c < int'(CH); c++) begin
                s_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            hb_q       <= hb_q + OneHb;
            if (cfg_en) begin
                key_q <= {key_q[M-2:0], cfg_i};
            end
            if (commit) begin
                mode_q <= mode;
            end
            for (int c = 0; c < int'(CH); c++) begin
                s_q[c] <= s_d[c];
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        cfg_o     = key_q[M-1];
        keyed     = (state_q == StRun);
        dout      = dout_q;
        dout_vld  = dout_vld_q;
        heartbeat = hb_q[HB_W-1 -: 3];
    end

endmodule

// File: tb/tb_xor_stream_cipher_mc.sv
// Self-checking bench for xor_stream_cipher_mc (M=8, CH=2, TAPS=8'hB8, HB_W=4).
// Expected output bits are queued when a strobe is driven and popped by a monitor.
module tb_xor_stream_cipher_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_en, cfg_i, cfg_o, mode, resync, keyed;
    logic [1:0] din, din_vld, dout, dout_vld;
    logic [2:0] heartbeat;

    typedef struct {
        logic v;
        int   cyc;
    } exp_t;

    exp_t sb [2][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    xor_stream_cipher_mc #(
        .M    (8),
        .CH   (2),
        .TAPS (8'hB8),
        .HB_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_i     (cfg_i),
        .cfg_o     (cfg_o),
        .mode      (mode),
        .resync    (resync),
        .din       (din),
        .din_vld   (din_vld),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .keyed     (keyed),
        .heartbeat (heartbeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (dout_vld[c] !== 1'b0) begin
                total++;
                if (sb[c].size() == 0) begin
                    bad++;
                    $display("FAIL sb_ch%0d: unexpected dout_vld=%b dout=%b at cyc %0d, required no strobe",
                             c, dout_vld[c], dout[c], cyc);
                end else begin
                    e = sb[c].pop_front();
                    if (dout[c] !== e.v || cyc !== e.cyc) begin
                        bad++;
                        $display("FAIL sb_ch%0d: dout=%b at cyc %0d, required dout=%b at cyc %0d",
                                 c, dout[c], cyc, e.v, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push(input int c, input logic v);
        exp_t e;
        e.v   = v;
        e.cyc = cyc + 1;
        sb[c].push_back(e);
    endtask

    task automatic shift_key(input logic [7:0] k, input logic m);
        for (int i = 7; i >= 0; i--) begin
            cfg_en = 1'b1;
            cfg_i  = k[i];
            @(negedge clk);
        end
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        mode   = m;
        @(negedge clk);
        mode   = ~m;
    endtask

    task automatic strobe(input int c, input logic d, input logic ev);
        din[c]     = d;
        din_vld[c] = 1'b1;
        push(c, ev);
        @(negedge clk);
        din_vld[c] = 1'b0;
    endtask

    task automatic drain(output int left);
        repeat (3) @(negedge clk);
        left = sb[0].size() + sb[1].size();
        sb[0].delete();
        sb[1].delete();
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({dout, dout_vld, keyed, cfg_o, heartbeat} !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {dout, dout_vld, keyed, cfg_o, heartbeat});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        din_vld = 2'b11;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            total++;
            if (heartbeat !== 3'((n % 16) >> 1) || keyed !== 1'b0) begin
                bad++;
                $display("FAIL heartbeat_n%0d: hb=%0d keyed=%b, required hb=%0d keyed=0",
                         n, heartbeat, keyed, (n % 16) >> 1);
            end
        end
        din_vld = 2'b00;
    endtask

    task automatic test_rotate;
        logic [7:0] pat = 8'hA5;
        int left;
        shift_key(8'hA5, 1'b0);
        total++;
        if (keyed !== 1'b1 || cfg_o !== 1'b1) begin
            bad++;
            $display("FAIL rotate_keyed: keyed=%b cfg_o=%b, required 1 1", keyed, cfg_o);
        end
        for (int i = 0; i < 8; i++) strobe(0, 1'b0, pat[i]);
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL rotate_drain: %0d outputs missing, required 0", left);
        end
    endtask

    task automatic test_lfsr;
        logic [4:0] exp_bits = 5'b10001;
        int left;
        shift_key(8'h00, 1'b1);
        for (int i = 4; i >= 0; i--) strobe(0, 1'b0, exp_bits[i]);
        // States B3 and E1 both have LSB 1; din=1 must invert it.
        strobe(0, 1'b1, 1'b0);
        strobe(0, 1'b1, 1'b0);
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL lfsr_drain: %0d outputs missing, required 0", left);
        end
    endtask

    task automatic test_channels;
        int left;
        shift_key(8'hA5, 1'b0);
        strobe(0, 1'b0, 1'b1);
        strobe(0, 1'b0, 1'b0);
        strobe(0, 1'b0, 1'b1);
        strobe(1, 1'b0, 1'b1);
        strobe(0, 1'b0, 1'b0);
        strobe(0, 1'b0, 1'b0);
        strobe(0, 1'b0, 1'b1);
        strobe(1, 1'b1, 1'b1);
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL channels_drain: %0d outputs missing, required 0", left);
        end
    endtask

    task automatic test_resync;
        int left;
        shift_key(8'hA5, 1'b0);
        strobe(0, 1'b0, 1'b1);
        strobe(0, 1'b0, 1'b0);
        resync = 1'b1;
        strobe(0, 1'b0, 1'b1);
        resync = 1'b0;
        strobe(0, 1'b0, 1'b1);
        strobe(0, 1'b0, 1'b0);
        strobe(1, 1'b0, 1'b1);
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL resync_drain: %0d outputs missing, required 0", left);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat = 8'hA5;
        logic [1:0] d;
        int left;
        shift_key(8'hA5, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d       = 2'($urandom);
            din     = d;
            din_vld = 2'b11;
            push(0, d[0] ^ pat[i % 8]);
            push(1, d[1] ^ pat[i % 8]);
            @(negedge clk);
        end
        din_vld = 2'b00;
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL b2b_drain: %0d outputs missing, required 0", left);
        end
    endtask

    task automatic test_cfg_in_run;
        logic [7:0] old_key = 8'h3C;
        logic [7:0] new_key = 8'hA5;
        int left;
        shift_key(old_key, 1'b0);
        din[0]     = 1'b0;
        din_vld[0] = 1'b1;
        push(0, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            cfg_en = 1'b1;
            cfg_i  = new_key[8 - k];
            @(negedge clk);
            total++;
            if (dout_vld !== 2'b00 || keyed !== 1'b0 || (k <= 7 && cfg_o !== old_key[7 - k])) begin
                bad++;
                $display("FAIL cfg_run_k%0d: vld=%b keyed=%b cfg_o=%b, required vld=00 keyed=0 cfg_o=%b",
                         k, dout_vld, keyed, cfg_o, (k <= 7) ? old_key[7 - k] : cfg_o);
            end
        end
        cfg_en     = 1'b0;
        din_vld[0] = 1'b0;
        mode       = 1'b0;
        @(negedge clk);
        strobe(0, 1'b0, 1'b1);
        strobe(0, 1'b0, 1'b0);
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL cfg_run_drain: %0d outputs missing, required 0", left);
        end
    endtask

    task automatic test_reset_mid;
        int left;
        shift_key(8'hA5, 1'b0);
        din        = 2'b00;
        din_vld[0] = 1'b1;
        push(0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({dout, dout_vld, keyed, cfg_o, heartbeat} !== 9'b0) begin
            bad++;
            $display("FAIL reset_mid: got %b, required all zero",
                     {dout, dout_vld, keyed, cfg_o, heartbeat});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        din_vld = 2'b11;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total++;
            if (keyed !== 1'b0 || cfg_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_rekey_n%0d: keyed=%b cfg_o=%b, required 0 0", n, keyed, cfg_o);
            end
        end
        din_vld = 2'b00;
        shift_key(8'hA5, 1'b0);
        strobe(0, 1'b0, 1'b1);
        strobe(0, 1'b0, 1'b0);
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL reset_mid_drain: %0d outputs missing, required 0", left);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        cfg_en  = 1'b0;
        cfg_i   = 1'b0;
        mode    = 1'b0;
        resync  = 1'b0;
        din     = 2'b00;
        din_vld = 2'b00;
        test_reset;
        test_rotate;
        test_lfsr;
        test_channels;
        test_resync;
        test_back_to_back;
        test_cfg_in_run;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
